// File: rtl/mfcc_melbank_accum.sv
// Purpose: mel filterbank stage; weights each FFT power bin by its ROM entry {f, w} and sums into NUM_FILT energies.
// Latency: 3 cycles from the closing bin's accept to filter 0 on m_data; a full-rate frame takes NUM_BINS + 2 + NUM_FILT cycles.
// Backpressure: s_ready low while flushing and draining; m_data/m_idx/m_last hold while m_valid && !m_ready.
// Ports: clk/rst (sync, active high); s_data/s_valid/s_last/s_ready carry power bins in;
//        m_data/m_idx/m_valid/m_last/m_ready carry filter energies out; frame_err pulses on a frame-length mismatch.
// ROM contents come from ROM_INIT, a packed list of NUM_BINS words {f, w} with bin 0 in the low bits.
// The default (all ones) puts every bin in a filter index past NUM_FILT, so no bin contributes.
// INIT_FILE/FILE_FORMAT name the source table ROM_INIT was generated from; they are only sanity-checked here.
module mfcc_melbank_accum #(
    parameter int    NUM_FILT    = 24,
    parameter int    NUM_BINS    = 257,
    parameter int    PWR_WIDTH   = 32,
    parameter int    COEF_WIDTH  = 8,
    parameter int    ACC_WIDTH   = 48,
    parameter int    FIDX_WIDTH  = 7,
    parameter string INIT_FILE   = "NONE",
    parameter string FILE_FORMAT = "BIN",
    parameter logic [NUM_BINS*(FIDX_WIDTH+COEF_WIDTH)-1:0] ROM_INIT = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PWR_WIDTH-1:0]  s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [ACC_WIDTH-1:0]  m_data,
    output logic [FIDX_WIDTH-1:0] m_idx,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  frame_err
);

    localparam int ROM_W  = FIDX_WIDTH + COEF_WIDTH;
    localparam int PROD_W = PWR_WIDTH + COEF_WIDTH;
    // One spare bit above the wider operand so the saturation test sees any carry.
    localparam int SUM_W  = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 1;
    localparam int CNT_W  = $clog2(NUM_BINS);
    localparam int FI_W   = $clog2(NUM_FILT);

    localparam logic [CNT_W-1:0]      LAST_BIN  = CNT_W'(NUM_BINS - 1);
    localparam logic [FIDX_WIDTH-1:0] LAST_FILT = FIDX_WIDTH'(NUM_FILT - 1);
    localparam logic [ACC_WIDTH-1:0]  ACC_MAX   = '1;
    localparam logic [COEF_WIDTH:0]   W_ONE     = {1'b1, {COEF_WIDTH{1'b0}}};

    if (NUM_FILT < 2 || NUM_FILT > 64) begin : g_bad_filt
        $error("mfcc_melbank_accum: NUM_FILT must be 2..64");
    end
    if (FILE_FORMAT != "BIN" && FILE_FORMAT != "HEX") begin : g_bad_fmt
        $error("mfcc_melbank_accum: FILE_FORMAT must be BIN or HEX");
    end
    if (INIT_FILE == "") begin : g_bad_init
        $error("mfcc_melbank_accum: INIT_FILE must be NONE or a table name");
    end

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Constant coefficient table, one word per bin.
    logic [ROM_W-1:0] rom_mem [NUM_BINS];
    for (genvar b = 0; b < NUM_BINS; b++) begin : g_rom
        assign rom_mem[b] = ROM_INIT[b*ROM_W +: ROM_W];
    end

    state_t                  state_q,     state_d;
    logic                    flush_q,     flush_d;
    logic [CNT_W-1:0]        bin_cnt_q,   bin_cnt_d;
    logic [PWR_WIDTH-1:0]    p_q,         p_d;
    logic [ROM_W-1:0]        rom_q,       rom_d;
    logic                    v0_q,        v0_d;
    logic [PROD_W-1:0]       hi_q,        hi_d;
    logic [PROD_W-1:0]       lo_q,        lo_d;
    logic [FIDX_WIDTH-1:0]   f1_q,        f1_d;
    logic                    v1_q,        v1_d;
    logic [ACC_WIDTH-1:0]    acc_q [NUM_FILT];
    logic [ACC_WIDTH-1:0]    acc_d [NUM_FILT];
    logic [ACC_WIDTH-1:0]    m_data_q,    m_data_d;
    logic [FIDX_WIDTH-1:0]   m_idx_q,     m_idx_d;
    logic                    m_valid_q,   m_valid_d;
    logic                    m_last_q,    m_last_d;
    logic                    frame_err_q, frame_err_d;

    logic                    accept;
    logic                    hit_end;
    logic                    close;
    logic [COEF_WIDTH-1:0]   w0;
    logic [FIDX_WIDTH-1:0]   f0;
    logic [PROD_W-1:0]       acc_add;
    logic [SUM_W-1:0]        acc_sum;
    logic [FI_W-1:0]         nxt_fi;

    // Combinational so that s_ready is already high in the first cycle after rst drops.
    assign s_ready = (state_q == ST_ACCUM) && !rst;

    always_comb begin
        accept  = s_valid && s_ready;
        hit_end = (bin_cnt_q == LAST_BIN);
        close   = accept && (hit_end || s_last);
        w0      = rom_q[COEF_WIDTH-1:0];
        f0      = rom_q[ROM_W-1:COEF_WIDTH];
        acc_add = '0;
        acc_sum = '0;
        nxt_fi  = FI_W'(m_idx_q + 1'b1);

        state_d     = state_q;
        flush_d     = flush_q;
        bin_cnt_d   = bin_cnt_q;
        m_data_d    = m_data_q;
        m_idx_d     = m_idx_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        frame_err_d = 1'b0;

        // Stage 0: capture power and the ROM word for the bin being accepted.
        p_d   = s_data;
        rom_d = rom_mem[bin_cnt_q];
        v0_d  = accept;

        // Stage 1: rising (hi) and falling (lo) weighted products.
        hi_d = PROD_W'(p_q) * PROD_W'(w0);
        lo_d = PROD_W'(p_q) * PROD_W'(W_ONE - {1'b0, w0});
        f1_d = f0;
        v1_d = v0_q;

        // Stage 2: hi feeds filter f, lo feeds filter f-1; a filter takes at most one of them per bin.
        for (int j = 0; j < NUM_FILT; j++) begin
            acc_add = '0;
            if (v1_q && int'(f1_q) == j) begin
                acc_add = hi_q;
            end else if (v1_q && int'(f1_q) == j + 1) begin
                acc_add = lo_q;
            end
            acc_sum  = SUM_W'(acc_q[j]) + SUM_W'(acc_add);
            acc_d[j] = (acc_sum > SUM_W'(ACC_MAX)) ? ACC_MAX : acc_q[j] + ACC_WIDTH'(acc_add);
        end

        case (state_q)
            ST_ACCUM: begin
                if (close) begin
                    state_d     = ST_FLUSH;
                    flush_d     = 1'b0;
                    frame_err_d = hit_end ^ s_last;
                end else if (accept) begin
                    bin_cnt_d = bin_cnt_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                if (flush_q) begin
                    // The last bin lands in acc_d this cycle, so load filter 0 from the next-state value.
                    state_d   = ST_DRAIN;
                    m_valid_d = 1'b1;
                    m_idx_d   = '0;
                    m_data_d  = acc_d[0];
                    m_last_d  = (NUM_FILT == 1);
                end else begin
                    flush_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (m_ready) begin
                    if (m_last_q) begin
                        state_d   = ST_ACCUM;
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        m_idx_d   = '0;
                        m_data_d  = '0;
                        bin_cnt_d = '0;
                        for (int j = 0; j < NUM_FILT; j++) begin
                            acc_d[j] = '0;
                        end
                    end else begin
                        m_idx_d  = m_idx_q + 1'b1;
                        m_data_d = acc_q[nxt_fi];
                        m_last_d = ((m_idx_q + 1'b1) == LAST_FILT);
                    end
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            flush_q     <= 1'b0;
            bin_cnt_q   <= '0;
            p_q         <= '0;
            rom_q       <= '0;
            v0_q        <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            f1_q        <= '0;
            v1_q        <= 1'b0;
            for (int j = 0; j < NUM_FILT; j++) begin
                acc_q[j] <= '0;
            end
            m_data_q    <= '0;
            m_idx_q     <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            bin_cnt_q   <= bin_cnt_d;
            p_q         <= p_d;
            rom_q       <= rom_d;
            v0_q        <= v0_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            f1_q        <= f1_d;
            v1_q        <= v1_d;
            for (int j = 0; j < NUM_FILT; j++) begin
                acc_q[j] <= acc_d[j];
            end
            m_data_q    <= m_data_d;
            m_idx_q     <= m_idx_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign m_data    = m_data_q;
    assign m_idx     = m_idx_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mfcc_melbank_accum.sv
// Bench for mfcc_melbank_accum: two instances (48-bit and 16-bit accumulators) share one stimulus stream.
// Expected energies come from a per-bin reference model over a small test ROM.
// m_ready patterns: always high, 1-0-0 repeating, or random.
module tb_mfcc_melbank_accum;

    localparam int NF = 4;
    localparam int NB = 8;
    localparam int RW = 15;

    function automatic logic [NB*RW-1:0] mk_rom();
        logic [NB*RW-1:0] r;
        for (int b = 0; b < NB; b++) r[b*RW +: RW] = {7'd127, 8'd0};
        r[3*RW +: RW] = {7'd2, 8'd128};
        r[5*RW +: RW] = {7'd4, 8'd0};
        return r;
    endfunction

    localparam logic [NB*RW-1:0] TEST_ROM = mk_rom();

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        m_ready = 1'b0;

    logic        s_ready,  s2_ready;
    logic [47:0] m_data;
    logic [15:0] m2_data;
    logic [6:0]  m_idx,    m2_idx;
    logic        m_valid,  m2_valid;
    logic        m_last,   m2_last;
    logic        frame_err, f2_err;

    mfcc_melbank_accum #(
        .NUM_FILT(NF), .NUM_BINS(NB), .PWR_WIDTH(32), .COEF_WIDTH(8),
        .ACC_WIDTH(48), .FIDX_WIDTH(7), .ROM_INIT(TEST_ROM)
    ) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .m_data(m_data), .m_idx(m_idx), .m_valid(m_valid),
        .m_last(m_last), .m_ready(m_ready), .frame_err(frame_err)
    );

    mfcc_melbank_accum #(
        .NUM_FILT(NF), .NUM_BINS(NB), .PWR_WIDTH(32), .COEF_WIDTH(8),
        .ACC_WIDTH(16), .FIDX_WIDTH(7), .ROM_INIT(TEST_ROM)
    ) dut_s (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s2_ready), .m_data(m2_data), .m_idx(m2_idx), .m_valid(m2_valid),
        .m_last(m2_last), .m_ready(m_ready), .frame_err(f2_err)
    );

    always #5 clk = ~clk;

    int                n_chk = 0;
    int                n_pass = 0;
    logic [31:0]       pwr    [NB];
    int                rom_f  [NB];
    longint unsigned   rom_w  [NB];
    longint unsigned   exp48  [NF];
    longint unsigned   exp16  [NF];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, expv);
    endtask

    // Reference: each bin adds p*w to filter f (if f < NF) and p*(256-w) to filter f-1 (if 1 <= f <= NF).
    task automatic build_exp(input int nb);
        longint unsigned e [NF];
        longint unsigned p;
        for (int i = 0; i < NF; i++) e[i] = 0;
        for (int b = 0; b < nb; b++) begin
            p = pwr[b];
            if (rom_f[b] < NF) e[rom_f[b]] += p * rom_w[b];
            if (rom_f[b] >= 1 && rom_f[b] <= NF) e[rom_f[b] - 1] += p * (256 - rom_w[b]);
        end
        for (int i = 0; i < NF; i++) begin
            exp48[i] = (e[i] > 64'hFFFF_FFFF_FFFF) ? 64'hFFFF_FFFF_FFFF : e[i];
            exp16[i] = (e[i] > 64'hFFFF) ? 64'hFFFF : e[i];
        end
    endtask

    function automatic logic next_rdy(input int mode, input int cyc);
        if (mode == 1) return (cyc % 3) == 0;
        if (mode == 2) return 1'($urandom_range(1));
        return 1'b1;
    endfunction

    task automatic send_frame(input int nb, input bit last_flag, input int bubble_pct);
        bit acc;
        int guard;
        for (int b = 0; b < nb; b++) begin
            s_valid = 1'b0;
            while ($urandom_range(99) < bubble_pct) begin
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = pwr[b];
            s_last  = last_flag && (b == nb - 1);
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 50) begin
                @(negedge clk);
                acc = s_ready;
                guard++;
                @(posedge clk); #1;
            end
            if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = $urandom();
    endtask

    task automatic run_frame(input int nb, input bit last_flag, input int mode,
                             input int bubble_pct, input int stop_after);
        int got, lat, first_lat, err_cnt, err2_cnt, err_cyc, cyc;
        bit exp_err, rdy_bad, held_vld;
        logic [47:0] held_d;
        logic [6:0]  held_i;
        build_exp(nb);
        exp_err = (nb == NB) != last_flag;
        m_ready = 1'b1;
        send_frame(nb, last_flag, bubble_pct);
        got = 0; lat = 0; first_lat = -1; err_cnt = 0; err2_cnt = 0; err_cyc = -1;
        rdy_bad = 1'b0; held_vld = 1'b0; cyc = 0;
        held_d = '0; held_i = '0;
        m_ready = next_rdy(mode, cyc);
        while (got < NF && lat < 200) begin
            @(negedge clk);
            lat++;
            if (frame_err) begin err_cnt++; err_cyc = lat; end
            if (f2_err) err2_cnt++;
            if (s_ready) rdy_bad = 1'b1;
            if (m_valid && first_lat < 0) first_lat = lat;
            if (held_vld) begin
                chk("hold_valid", 64'(m_valid), 64'd1);
                chk("hold_data", 64'(m_data), 64'(held_d));
                chk("hold_idx", 64'(m_idx), 64'(held_i));
            end
            held_vld = m_valid && !m_ready;
            held_d = m_data;
            held_i = m_idx;
            if (m_valid && m_ready) begin
                chk("idx", 64'(m_idx), 64'(got));
                chk("energy48", 64'(m_data), exp48[got]);
                chk("last", 64'(m_last), 64'(got == NF - 1));
                chk("valid16", 64'(m2_valid), 64'd1);
                chk("energy16", 64'(m2_data), exp16[got]);
                got++;
                if (got == stop_after) break;
            end
            @(posedge clk); #1;
            cyc++;
            m_ready = next_rdy(mode, cyc);
        end
        chk("first_valid_latency", 64'(first_lat), 64'd3);
        chk("frame_err_pulses", 64'(err_cnt), 64'(exp_err));
        chk("frame_err_pulses16", 64'(err2_cnt), 64'(exp_err));
        if (exp_err) chk("frame_err_cycle", 64'(err_cyc), 64'd1);
        chk("s_ready_low_in_drain", 64'(rdy_bad), 64'd0);
        if (stop_after < NF) begin
            chk("partial_drain", 64'(got), 64'(stop_after));
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            chk("rst_m_valid", 64'(m_valid), 64'd0);
            chk("rst_m_valid16", 64'(m2_valid), 64'd0);
            chk("rst_s_ready", 64'(s_ready), 64'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            return;
        end
        chk("drain_count", 64'(got), 64'(NF));
        @(negedge clk);
        chk("s_ready_after_last", 64'(s_ready), 64'd1);
        chk("m_valid_after_last", 64'(m_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic clear_pwr();
        for (int b = 0; b < NB; b++) pwr[b] = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int b = 0; b < NB; b++) begin rom_f[b] = 127; rom_w[b] = 0; end
        rom_f[3] = 2; rom_w[3] = 128;
        rom_f[5] = 4; rom_w[5] = 0;

        // Reset: outputs low while held, s_ready high right after release.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_s_ready16", 64'(s2_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_idx", 64'(m_idx), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("s_ready_after_rst", 64'(s_ready), 64'd1);
        repeat (4) begin
            @(negedge clk);
            chk("idle_m_valid", 64'(m_valid), 64'd0);
        end
        @(posedge clk); #1;

        // Single frame, then a falling-only bin.
        clear_pwr(); pwr[3] = 32'd100;
        run_frame(NB, 1'b1, 0, 0, NF);
        clear_pwr(); pwr[5] = 32'd7;
        run_frame(NB, 1'b1, 0, 0, NF);

        // Backpressure 1,0,0 pattern.
        clear_pwr(); pwr[3] = 32'd100;
        run_frame(NB, 1'b1, 1, 0, NF);

        // Early s_last on bin 5, then a normal frame.
        clear_pwr(); pwr[3] = 32'd100; pwr[5] = 32'd7;
        run_frame(6, 1'b1, 0, 0, NF);
        clear_pwr(); pwr[3] = 32'd100;
        run_frame(NB, 1'b1, 0, 0, NF);

        // Full-length frame without s_last.
        clear_pwr(); pwr[3] = 32'd55; pwr[5] = 32'd9;
        run_frame(NB, 1'b0, 0, 0, NF);

        // Saturation on the 16-bit instance.
        clear_pwr(); pwr[3] = 32'hFFFF_FFFF;
        run_frame(NB, 1'b1, 0, 0, NF);

        // Reset in the middle of draining, then a clean frame.
        clear_pwr(); pwr[3] = 32'd100;
        run_frame(NB, 1'b1, 0, 0, 2);
        run_frame(NB, 1'b1, 0, 0, NF);

        // Random powers, lengths, bubbles and m_ready.
        for (int r = 0; r < 8; r++) begin
            int  nb;
            bit  lf;
            for (int b = 0; b < NB; b++) pwr[b] = $urandom();
            nb = $urandom_range(3, NB);
            lf = (nb < NB) ? 1'b1 : 1'($urandom_range(1));
            run_frame(nb, lf, 2, 25, NF);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mfcc_melbank_accum.md
# mfcc_melbank_accum

Parametrised mel filterbank stage for the MFCC chain. It takes a frame of FFT power bins as a stream and looks up each bin's triangular-filter weight in an internal distributed coefficient ROM. It accumulates weighted power into NUM_FILT filter energies and streams the energies out in filter order. It replaces the fixed-width, per-filter ROMs with one table-driven engine that has configurable width, depth and filter count.

## Interface
- NUM_FILT, 24: number of mel filters (2..64).
- NUM_BINS, 257: power bins per frame (8..1024).
- PWR_WIDTH, 32: input power width.
- COEF_WIDTH, 8: weight width; weights are unsigned Q0.COEF_WIDTH.
- ACC_WIDTH, 48: accumulator and output width.
- FIDX_WIDTH, 7: filter-index field width in the ROM word.
- INIT_FILE, "NONE": coefficient ROM init file, NUM_BINS words of {f, w}.
- FILE_FORMAT, "BIN": BIN or HEX.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_data  in  PWR_WIDTH  power of the current bin.
- s_valid  in  1  s_data valid.
- s_last  in  1  last bin of frame.
- s_ready  out  1  bin accepted when s_valid&&s_ready.
- m_data  out  ACC_WIDTH  filter energy.
- m_idx  out  FIDX_WIDTH  filter index of m_data.
- m_valid  out  1  output valid.
- m_last  out  1  asserted with filter NUM_FILT-1.
- m_ready  in  1  downstream accept.
- frame_err  out  1  one-cycle pulse: frame length mismatch.

## Operation
- ROM word for bin b is {f, w}. Define hi = p*w and lo = p*(2^COEF_WIDTH - w), each PWR_WIDTH+COEF_WIDTH bits.
  - If f < NUM_FILT: acc[f] += hi.
  - If 1 <= f <= NUM_FILT: acc[f-1] += lo.
  - If f > NUM_FILT: no contribution.
- Accumulation is saturating unsigned. On overflow, acc holds 2^ACC_WIDTH-1.
- The accumulators are a register array with single-cycle read-modify-write, so back-to-back updates to the same filter need no stall.
- Both accumulator updates for a bin happen in the same cycle.
- FSM:
  - ACCUM: s_ready=1. Each accepted bin increments bin_cnt, which is the ROM address. s_valid low inserts a bubble; the pipeline still drains its valid stages.
  - The frame closes on the accepted bin where bin_cnt==NUM_BINS-1 or s_last=1, whichever comes first.
  - If exactly one of these two conditions holds on the closing bin, frame_err pulses in the first FLUSH cycle.
  - ACCUM→FLUSH on frame close.
  - FLUSH: s_ready=0. Waits 2 cycles for the pipeline to empty, then →DRAIN.
  - DRAIN: s_ready=0. Presents acc[0..NUM_FILT-1] in order. m_idx advances on each m_valid&&m_ready.
  - On the handshake with m_last, go →ACCUM, clear all accumulators and set bin_cnt=0.

## Timing
- Pipeline:
  - Cycle 0: accept the bin and register p; the ROM read is registered.
  - Cycle 1: multiply and register.
  - Cycle 2: accumulate.
- The last bin's contribution lands at the end of the second FLUSH cycle. m_valid for filter 0 rises in the next cycle.
- A frame of NUM_BINS bins with s_valid continuous and m_ready held high takes NUM_BINS + 2 + NUM_FILT cycles. s_ready rises again the cycle after the m_last handshake.
- The output registers hold while m_valid&&!m_ready. m_data and m_idx are stable under backpressure.
- Reset values (rst sampled high at a clk edge):
  - Outputs: s_ready=0, m_valid=0, m_data=0, m_idx=0, m_last=0, frame_err=0.
  - Internal: FSM=ACCUM, bin_cnt=0, all acc=0, pipeline valids=0.
  - s_ready=1 in the first cycle with rst low.
- Reset mid-frame or mid-drain discards all partial state. The next frame is unaffected.
- Inputs in ACCUM while s_ready=0 (FLUSH/DRAIN) are ignored and not lost: the upstream holds them per the handshake.

## Test plan
- Setup for all tests except where noted: NUM_FILT=4, NUM_BINS=8, ACC_WIDTH=48, COEF_WIDTH=8, PWR_WIDTH=32, with a test ROM:
  - bin3 = {f=2, w=128}.
  - bin5 = {f=4, w=0}.
  - All other bins = {f=127, w=0}.
- Reset: hold rst 3 cycles -> every output 0 during reset; s_ready=1 in the first cycle after release; m_valid stays 0 with no input.
- Single frame: p=100 on bin3, p=0 elsewhere, m_ready=1 -> outputs idx0..3 = 0, 12800, 12800, 0; m_last on idx3; first m_valid 3 cycles after the 8th accept.
- Falling-only bin: p=7 on bin5, p=0 elsewhere -> acc[3]=1792, others 0.
- Backpressure: same stimulus as single frame with m_ready toggling 1,0,0,1,… -> identical values in idx order 0..3; m_data held while stalled; s_ready stays 0 until the m_last handshake.
- Early s_last: s_last on bin 5 -> frame_err pulses one cycle; drain outputs bins 0..5 contributions; next frame restarts at bin_cnt=0 with correct results.
- Saturation and mid-drain reset:
  - With ACC_WIDTH=16 and p=0xFFFFFFFF on bin3 -> idx1 and idx2 read 0xFFFF.
  - Assert rst during DRAIN -> m_valid=0 next cycle; a following p=100 frame yields 12800, 12800 exactly.
